multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM that sequences the shared processor datapath (register file, ALU, immediate generator, unified instruction/data memory) across several clocks per instruction. It issues per-state datapath control, handshakes with a single memory port, and counts retired instructions. It sits beside the datapath and takes the opcode from the instruction register.

## Interface
- Parameters:
- CNT_W, 32, width of retired-instruction counter
- Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  7  instruction register [6:0]
- zero  in  1  ALU zero flag (branch compare, rs1−rs2)
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (1) / read (0), valid with mem_req
- iord  out  1  address select: 0 PC, 1 ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 ALU result, 1 ALUOut
- alu_src_a  out  1  0 PC, 1 rs1
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 ImmExt
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_write  out  1  register file write
- mem_to_reg  out  1  writeback source: 0 ALUOut, 1 MDR
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- illegal  out  1  illegal-opcode flag (see Configuration)

## Operation
- States: FETCH, DECODE, EX_R, EX_ADDR, EX_BR, MEM_RD, MEM_WR, WB_R, WB_LD, TRAP.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00; hold until mem_ready; in the ready cycle ir_write=1, pc_write=1, pc_src=0, → DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next by opcode: 0110011 → EX_R; 0000011/0100011 → EX_ADDR; 1100011 → EX_BR; other → illegal handling.
- EX_R: alu_src_a=1, alu_src_b=00, alu_op=10 → WB_R.
- EX_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD (load) or MEM_WR (store).
- EX_BR: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero; retire=1 → FETCH.
- MEM_RD: mem_req=1, iord=1, mem_we=0; hold until mem_ready → WB_LD.
- MEM_WR: mem_req=1, iord=1, mem_we=1; hold until mem_ready; retire=1 in ready cycle → FETCH.
- WB_R: reg_write=1, mem_to_reg=0, retire=1 → FETCH. WB_LD: reg_write=1, mem_to_reg=1, retire=1 → FETCH.
- All controls not listed for a state are 0.
- instret increments by 1 on each retire; wraps 2^CNT_W−1 → 0.

## Timing
- Reset: rst_n=0 at a rising edge → state FETCH, instret=0, illegal=0. While rst_n=0 every output is 0 (combinationally gated). Reset mid-instruction abandons it, no retire.
- State-based controls are Moore; ir_write, pc_write (FETCH), retire (MEM_WR) are qualified by mem_ready same cycle.
- mem_req stays high with stable iord/mem_we until mem_ready; mem_ready while mem_req=0 is ignored.
- Zero-wait latency (FETCH to retire, inclusive): branch 3, R-type 4, store 4, load 5. Each wait cycle adds 1.
- retire and instret update on the same edge as the final-state exit.

## Configuration
- MULTICYCLE_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE → TRAP; illegal=1 sticky, all controls 0, no retire, exits only on reset.
- Undefined: unknown opcode treated as NOP: DECODE → FETCH with retire=1; illegal tied 0; TRAP state absent.

## Structure
- Shared package: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE), state enum, alu_op and alu_src_b encodings — shared with immediate generator and ALU control.
- One sub-module natural: multicycle_ctrl_decode (combinational state → control-vector map); FSM, counter, and illegal flag stay in the top.

## Test plan
- Reset: rst_n=0 for 2 cycles mid-MEM_RD → all outputs 0, instret=0; first post-reset cycle mem_req=1, iord=0.
- R-type 0110011, mem_ready tied 1 → retire on cycle 4, reg_write=1 in WB_R only, instret 0→1.
- Load 0000011 with 2 wait cycles in MEM_RD → mem_req/iord=1 held 3 cycles, retire at cycle 7, mem_to_reg=1.
- Branch 1100011, zero=1 then zero=0 → pc_write=1 with pc_src=1 in first EX_BR, 0 in second; both retire in 3 cycles.
- instret preloaded to 0xFFFF_FFFF via 2^32−1 retires (or forced) + store → wraps to 0.
- Opcode 1111111: with macro → illegal=1, stuck in TRAP, no retire; without → retire after 2 cycles, illegal=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control path: opcode constants, the
// controller state encoding, and the alu_op / alu_src_b encodings also used by
// the immediate generator and ALU control.
// Build option: MULTICYCLE_ILLEGAL_TRAP_EN adds the TRAP state.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExR    = 4'd2,
    StExAddr = 4'd3,
    StExBr   = 4'd4,
    StMemRd  = 4'd5,
    StMemWr  = 4'd6,
    StWbR    = 4'd7,
    StWbLd   = 4'd8
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , StTrap = 4'd9
`endif
  } state_e;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_RTYPE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> datapath control map for the multi-cycle controller.
// Ports:
//   state      current controller state (state_e encoding)
//   mem_ready  memory completes the current access this cycle
//   zero       ALU zero flag (branch compare)
//   mem_req/mem_we/iord, ir_write/pc_write/pc_src, alu_src_a/alu_src_b/alu_op,
//   reg_write/mem_to_reg, retire: per-state control outputs
// Any state not listed (e.g. TRAP when MULTICYCLE_ILLEGAL_TRAP_EN is defined)
// drives all controls to 0.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       retire
);

  state_e st;
  assign st = state_e'(state);

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    unique case (st)
      StFetch: begin
        // ALU computes PC+4 while the instruction is read.
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        // Branch target PC+imm lands in ALUOut for a possible EX_BR.
        alu_src_b = SRC_B_IMM;
      end
      StExR: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      StExAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      StExBr: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        retire  = mem_ready;
      end
      StWbR: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      StWbLd: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared processor datapath.
// Sequences fetch/decode/execute/memory/writeback, handshakes with a single
// memory port and counts retired instructions.
// Ports:
//   clk, rst_n (synchronous, active-low; all outputs forced 0 while low)
//   opcode     instruction register [6:0]
//   zero       ALU zero flag
//   mem_ready  memory completes current access this cycle
//   mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
//   alu_op, reg_write, mem_to_reg  datapath controls
//   retire     one-cycle pulse per completed instruction
//   instret    retired-instruction count (CNT_W bits, wraps)
//   illegal    sticky illegal-opcode flag
// Build option: MULTICYCLE_ILLEGAL_TRAP_EN -- unknown opcodes trap (sticky
// illegal, no retire, exit only by reset). Otherwise they retire as a NOP.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             known_op;
  logic             nop_retire;
  logic             retire_int;

  logic       dec_mem_req, dec_mem_we, dec_iord, dec_ir_write, dec_pc_write, dec_pc_src;
  logic       dec_alu_src_a, dec_reg_write, dec_mem_to_reg, dec_retire;
  logic [1:0] dec_alu_src_b, dec_alu_op;

  assign known_op = is_known_op(opcode);

  multicycle_ctrl_decode u_decode (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .mem_req    (dec_mem_req),
    .mem_we     (dec_mem_we),
    .iord       (dec_iord),
    .ir_write   (dec_ir_write),
    .pc_write   (dec_pc_write),
    .pc_src     (dec_pc_src),
    .alu_src_a  (dec_alu_src_a),
    .alu_src_b  (dec_alu_src_b),
    .alu_op     (dec_alu_op),
    .reg_write  (dec_reg_write),
    .mem_to_reg (dec_mem_to_reg),
    .retire     (dec_retire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_RTYPE:          state_d = StExR;
          OP_LOAD, OP_STORE: state_d = StExAddr;
          OP_BRANCH:         state_d = StExBr;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:           state_d = StTrap;
`else
          default:           state_d = StFetch;
`endif
        endcase
      end
      StExR:    state_d = StWbR;
      StExAddr: state_d = (opcode == OP_STORE) ? StMemWr : StMemRd;
      StExBr:   state_d = StFetch;
      StMemRd:  if (mem_ready) state_d = StWbLd;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StWbR:    state_d = StFetch;
      StWbLd:   state_d = StFetch;
      default:  state_d = state_q;
    endcase
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign nop_retire = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (state_q == StDecode && !known_op) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = rst_n & illegal_q;
`else
  // Unknown opcodes complete in DECODE as a NOP.
  assign nop_retire = (state_q == StDecode) && !known_op;
  assign illegal    = 1'b0;
`endif

  assign retire_int = dec_retire | nop_retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_int) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Outputs are gated combinationally so nothing leaks while reset is held.
  assign mem_req    = rst_n & dec_mem_req;
  assign mem_we     = rst_n & dec_mem_we;
  assign iord       = rst_n & dec_iord;
  assign ir_write   = rst_n & dec_ir_write;
  assign pc_write   = rst_n & dec_pc_write;
  assign pc_src     = rst_n & dec_pc_src;
  assign alu_src_a  = rst_n & dec_alu_src_a;
  assign alu_src_b  = rst_n ? dec_alu_src_b : 2'b00;
  assign alu_op     = rst_n ? dec_alu_op : 2'b00;
  assign reg_write  = rst_n & dec_reg_write;
  assign mem_to_reg = rst_n & dec_mem_to_reg;
  assign retire     = rst_n & retire_int;
  assign instret    = rst_n ? instret_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Counter width is reduced so the
// wrap from all-ones to zero is reached quickly.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 8;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_RTYPE  = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]    alu_src_b, alu_op;
  logic          reg_write, mem_to_reg, retire, illegal;
  logic [CW-1:0] instret;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  logic [6:0] bad_ops [4] = '{7'b1111111, 7'b0010011, 7'b0110111, 7'b0000000};

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .retire     (retire),
    .instret    (instret),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_ctrl();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
            reg_write, mem_to_reg, retire, illegal};
  endfunction

  // Called at posedge+1: apply inputs, sample settled outputs, advance one clock.
  task automatic tick_after_sample();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH. fw/mw: wait cycles on fetch/memory access.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    bit is_r, is_ld, is_st, is_br, is_mem;
    int total, mem_start, exp_last_ctl;
    int n_req, n_iord, n_we, n_irw, n_pcw, n_pcsrc, n_rw, n_m2r, n_ret;
    bit ret_last;
    is_r   = (op == T_RTYPE);
    is_ld  = (op == T_LOAD);
    is_st  = (op == T_STORE);
    is_br  = (op == T_BRANCH);
    is_mem = is_ld || is_st;
    if (is_r)       total = fw + 4;
    else if (is_ld) total = fw + mw + 5;
    else if (is_st) total = fw + mw + 4;
    else if (is_br) total = fw + 3;
    else            total = fw + 2;
    mem_start = fw + 3;
    // {alu_src_a, alu_src_b, alu_op} expected in the cycle after DECODE.
    exp_last_ctl = is_r ? 5'b1_00_10 : is_br ? 5'b1_00_01 : 5'b1_10_00;
    {n_req, n_iord, n_we, n_irw, n_pcw, n_pcsrc, n_rw, n_m2r, n_ret} = '0;
    ret_last = 1'b0;
    opcode = op;
    for (int c = 0; c < total; c++) begin
      if (c < fw) mem_ready = 1'b0;
      else if (c == fw) mem_ready = 1'b1;
      else if (is_mem && c >= mem_start) mem_ready = (c == mem_start + mw);
      else mem_ready = 1'($urandom_range(0, 1));
      zero = (is_br && c == fw + 2) ? z : 1'($urandom_range(0, 1));
      #1;
      if (c == 0) check("fetch_ctl", {mem_req, iord, alu_src_a, alu_src_b, alu_op}, 7'b1_0_0_01_00);
      if (c == fw + 1) check("decode_ctl", {alu_src_a, alu_src_b, alu_op}, 5'b0_10_00);
      if (c == fw + 2 && (is_r || is_br || is_mem))
        check("exec_ctl", {alu_src_a, alu_src_b, alu_op}, exp_last_ctl);
      n_req   += int'(mem_req);
      n_iord  += int'(iord);
      n_we    += int'(mem_we);
      n_irw   += int'(ir_write);
      n_pcw   += int'(pc_write);
      n_pcsrc += int'(pc_src);
      n_rw    += int'(reg_write);
      n_m2r   += int'(mem_to_reg);
      n_ret   += int'(retire);
      if (c == total - 1) ret_last = retire;
      tick_after_sample();
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    check("retire_last", 32'(ret_last), 1);
    check("retire_count", n_ret, 1);
    check("mem_req_cycles", n_req, fw + 1 + (is_mem ? mw + 1 : 0));
    check("iord_cycles", n_iord, is_mem ? mw + 1 : 0);
    check("mem_we_cycles", n_we, is_st ? mw + 1 : 0);
    check("ir_write_cycles", n_irw, 1);
    check("pc_write_cycles", n_pcw, 1 + ((is_br && z) ? 1 : 0));
    check("pc_src_cycles", n_pcsrc, is_br ? 1 : 0);
    check("reg_write_cycles", n_rw, (is_r || is_ld) ? 1 : 0);
    check("mem_to_reg_cycles", n_m2r, is_ld ? 1 : 0);
    check("instret", 32'(instret), exp_cnt);
    check("illegal_low", 32'(illegal), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = T_RTYPE;
    zero = 1'b0;
    mem_ready = 1'b1;
    #1;
    // Reset held: everything gated to zero regardless of inputs.
    for (int i = 0; i < 2; i++) begin
      #1;
      check("reset_ctrl", 32'(all_ctrl()), 0);
      check("reset_instret", 32'(instret), 0);
      tick_after_sample();
    end
    rst_n = 1'b1;

    // Directed: R-type, load with two memory waits, branch taken / not taken.
    run_instr(T_RTYPE, 0, 0, 1'b0);
    run_instr(T_LOAD, 0, 2, 1'b0);
    run_instr(T_BRANCH, 0, 0, 1'b1);
    run_instr(T_BRANCH, 0, 0, 1'b0);
    run_instr(T_STORE, 1, 1, 1'b0);
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 0, 0, 1'b0);
`endif

    // Reset in the middle of a load's memory wait: abandoned, no retire.
    opcode = T_LOAD;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 0);
      #1;
      tick_after_sample();
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      #1;
      check("midreset_ctrl", 32'(all_ctrl()), 0);
      check("midreset_instret", 32'(instret), 0);
      tick_after_sample();
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    mem_ready = 1'b0;
    #1;
    check("post_reset_fetch", {mem_req, iord, retire}, 3'b100);
    check("post_reset_instret", 32'(instret), 0);

    // Randomized instruction mix.
    for (int n = 0; n < 300; n++) begin
      int cls;
      logic [6:0] op;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      cls = $urandom_range(0, 3);
`else
      cls = $urandom_range(0, 4);
`endif
      case (cls)
        0:       op = T_RTYPE;
        1:       op = T_LOAD;
        2:       op = T_STORE;
        3:       op = T_BRANCH;
        default: op = bad_ops[$urandom_range(0, 3)];
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Counter wrap: step up to all-ones, then a store takes it to zero.
    while (exp_cnt != (1 << CW) - 1) run_instr(T_STORE, 0, 0, 1'b0);
    check("instret_max", 32'(instret), (1 << CW) - 1);
    run_instr(T_STORE, 0, 0, 1'b0);
    check("instret_wrap", 32'(instret), 0);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    // Unknown opcode traps: sticky illegal, no controls, no retire.
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    #1;
    tick_after_sample();
    #1;
    check("trap_decode_retire", 32'(retire), 0);
    tick_after_sample();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      opcode = T_RTYPE;
      #1;
      check("trap_ctrl", 32'(all_ctrl()), 15'h0001);
      check("trap_instret", 32'(instret), exp_cnt);
      tick_after_sample();
    end
    rst_n = 1'b0;
    #1;
    tick_after_sample();
    rst_n = 1'b1;
    exp_cnt = 0;
    #1;
    check("trap_cleared", 32'(illegal), 0);
    run_instr(T_RTYPE, 0, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
